// File: rtl/led_pwm_ctrl_if.sv
// Peripheral bus bundle for led_pwm_ctrl.
//
// Handshake: wen and ren are single-cycle strobes with no backpressure.
// A strobe high at a rising clk edge is accepted on that edge: wen commits
// wdata to the register at addr, ren loads rdata with the value the register
// held before the edge. rdata is registered and holds until the next ren.
// wen and ren may be high together; the read then returns the old value.
interface led_pwm_ctrl_if;
   logic        wen;
   logic        ren;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output wen, ren, addr, wdata, input rdata);
   modport slave  (input wen, ren, addr, wdata, output rdata);
endinterface

// File: rtl/led_pwm_ctrl.sv
// Bus-mapped LED controller: a DATA pattern gated by static, blink or PWM
// mode. A free-running PWM counter and a programmable blink divider run
// continuously; the selected gate is registered into the led outputs.
module led_pwm_ctrl #(
   parameter int N_LED    = 24,
   parameter int PWM_BITS = 8,
   parameter int DIV_W    = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   led_pwm_ctrl_if.slave     bus,
   output logic [N_LED-1:0]  led
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_MODE   = 3'd1;
   localparam logic [2:0] ADDR_DUTY   = 3'd2;
   localparam logic [2:0] ADDR_PERIOD = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   localparam logic [1:0] MODE_BLINK = 2'd1;
   localparam logic [1:0] MODE_PWM   = 2'd2;

   localparam logic [PWM_BITS-1:0] PCNT_ONE = 1;
   localparam logic [DIV_W-1:0]    BCNT_ONE = 1;

   logic [N_LED-1:0]    data_r;
   logic [1:0]          mode_r;
   logic [PWM_BITS-1:0] duty_r;
   logic [DIV_W-1:0]    period_r;
   logic [PWM_BITS-1:0] pcnt;
   logic [DIV_W-1:0]    bcnt;
   logic                phase;
   logic                pwm_on;
   logic                gate;
   logic [31:0]         rd_mux;
   logic                wr_data, wr_mode, wr_duty, wr_period;

   // Only the low wdata bits are stored; the rest are deliberately dropped.
   logic unused_wdata;
   assign unused_wdata = ^bus.wdata;

   assign wr_data   = bus.wen && (bus.addr == ADDR_DATA);
   assign wr_mode   = bus.wen && (bus.addr == ADDR_MODE);
   assign wr_duty   = bus.wen && (bus.addr == ADDR_DUTY);
   assign wr_period = bus.wen && (bus.addr == ADDR_PERIOD);

   // Software-visible configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r   <= '0;
         mode_r   <= '0;
         duty_r   <= '0;
         period_r <= '0;
      end else begin
         if (wr_data)   data_r   <= bus.wdata[N_LED-1:0];
         if (wr_mode)   mode_r   <= bus.wdata[1:0];
         if (wr_duty)   duty_r   <= bus.wdata[PWM_BITS-1:0];
         if (wr_period) period_r <= bus.wdata[DIV_W-1:0];
      end
   end

   // Free-running PWM counter, runs in every mode and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pcnt <= '0;
      else        pcnt <= pcnt + PCNT_ONE;
   end

   // Blink divider: a PERIOD write restarts in the on phase; PERIOD 0 holds on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (wr_period || (period_r == '0)) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (bcnt == period_r - BCNT_ONE) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt  <= bcnt + BCNT_ONE;
      end
   end

   // Gate select from the current mode; mode 3 falls back to static.
   always_comb begin
      pwm_on = (pcnt < duty_r);
      gate   = 1'b1;
      case (mode_r)
         MODE_BLINK: gate = phase;
         MODE_PWM:   gate = pwm_on;
         default:    gate = 1'b1;
      endcase
   end

   // LED drive registered one cycle behind the gate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led <= '0;
      else        led <= data_r & {N_LED{gate}};
   end

   // Read mux over pre-edge register values; unmapped bits and offsets read 0.
   always_comb begin
      rd_mux = '0;
      case (bus.addr)
         ADDR_DATA:   rd_mux[N_LED-1:0]    = data_r;
         ADDR_MODE:   rd_mux[1:0]          = mode_r;
         ADDR_DUTY:   rd_mux[PWM_BITS-1:0] = duty_r;
         ADDR_PERIOD: rd_mux[DIV_W-1:0]    = period_r;
         ADDR_STATUS: begin
            rd_mux[0]            = phase;
            rd_mux[PWM_BITS+7:8] = pcnt;
         end
         default:     rd_mux = '0;
      endcase
   end

   // Registered read data, held while ren is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       bus.rdata <= '0;
      else if (bus.ren) bus.rdata <= rd_mux;
   end

endmodule
